wb_vmon_msg_arbiter: RTL



---
 rtl/wb_vmon_msg_pkg.sv | 29 ++
 rtl/wb_vmon_msg_arbiter_rr.sv | 33 +++
 rtl/wb_vmon_msg_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_vmon_msg_pkg.sv
// Shared types for the vmon message arbiter: size codes, FSM states, lane mapping.
package wb_vmon_msg_pkg;

  typedef enum logic [1:0] {
    SZ_1B      = 2'd0,
    SZ_2B      = 2'd1,
    SZ_4B      = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // Byte 0 of the message always travels on lane 0; illegal sizes drive no lanes.
  function automatic logic [3:0] size_to_sel(input logic [1:0] sz);
    logic [3:0] sel;
    case (size_e'(sz))
      SZ_1B:   sel = 4'b0001;
      SZ_2B:   sel = 4'b0011;
      SZ_4B:   sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_vmon_msg_arbiter_rr.sv
// Round-robin pick: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    int k;
    k       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    if (i_en) begin
      for (int i = 0; i < N_REQ; i++) begin
        k = int'(i_ptr) + i;
        if (k >= N_REQ) k = k - N_REQ;
        if (!o_valid && i_req[k]) begin
          o_valid    = 1'b1;
          o_grant[k] = 1'b1;
          o_idx      = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/wb_vmon_msg_arbiter.sv
// Round-robin funnel of 1/2/4-byte vmon messages onto single Wishbone classic writes.
// Define WB_VMON_MSG_ARBITER_TIMEOUT_EN to bound each bus cycle to TIMEOUT_CYCLES.
module wb_vmon_msg_arbiter
  import wb_vmon_msg_pkg::*;
#(
  parameter int                       N_REQ          = 4,
  parameter int                       WB_ADDR_WIDTH  = 32,
  parameter int                       WB_DATA_WIDTH  = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS        = 'h0000_0000,
  parameter int                       TIMEOUT_CYCLES = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_REQ-1:0]               req_valid_i,
  output logic [N_REQ-1:0]               req_ready_o,
  input  logic [N_REQ*WB_DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ*2-1:0]             req_size_i,
  output logic [N_REQ-1:0]               rsp_valid_o,
  output logic                           rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0]       ADR,
  output logic [WB_DATA_WIDTH-1:0]       DAT_W,
  output logic                           CYC,
  output logic                           STB,
  output logic                           WE,
  output logic [3:0]                     SEL,
  input  logic                           ACK,
  input  logic                           ERR,
  output logic [1:0]                     dbg_state_o
);

  localparam int         IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUS  = ST_BUS;
  localparam logic [1:0] S_RSP  = ST_RSP;

  if (N_REQ < 1 || N_REQ > 16) begin : g_bad_nreq
    $error("N_REQ must be in 1..16");
  end
  if (WB_DATA_WIDTH != 32) begin : g_bad_dw
    $error("WB_DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]               r_state;
  logic [IDX_W-1:0]         r_ptr;
  logic [IDX_W-1:0]         r_gidx;
  logic [WB_DATA_WIDTH-1:0] r_data;
  logic [3:0]               r_sel;
  logic                     r_err;
  logic                     r_cyc;

  logic [N_REQ-1:0]         w_grant;
  logic [IDX_W-1:0]         w_gidx;
  logic                     w_any;
  logic                     w_en;
  logic [1:0]               w_sz;
  logic [WB_DATA_WIDTH-1:0] w_data;
  logic [IDX_W-1:0]         w_ptr_nxt;
  logic                     w_tmo_exp;
  logic                     w_term;

  // Handshake: a requester holds valid/data/size until it sees ready; ready is
  // one-hot and high only in the IDLE cycle its message is latched, so valid &&
  // ready marks the single transfer. Dropping valid early simply forgoes the grant.
  assign w_en = (r_state == S_IDLE) && rst_ni;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr (
    .i_req  (req_valid_i),
    .i_ptr  (r_ptr),
    .i_en   (w_en),
    .o_grant(w_grant),
    .o_idx  (w_gidx),
    .o_valid(w_any)
  );

  assign w_sz      = req_size_i[{w_gidx, 1'b0} +: 2];
  assign w_data    = req_data_i[int'(w_gidx) * WB_DATA_WIDTH +: WB_DATA_WIDTH];
  assign w_ptr_nxt = (w_gidx == IDX_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;

`ifdef WB_VMON_MSG_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // r_tmo counts BUS cycles already spent; the last allowed cycle expires it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo <= '0;
    end else if (r_state == S_IDLE) begin
      r_tmo <= '0;
    end else if (r_state == S_BUS) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo_exp = (r_state == S_BUS) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_exp = 1'b0;
`endif

  assign w_term = ACK || ERR || w_tmo_exp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gidx <= w_gidx;
            r_ptr  <= w_ptr_nxt;
            r_data <= w_data;
            r_sel  <= size_to_sel(w_sz);
            if (w_sz == SZ_ILLEGAL) begin
              r_err   <= 1'b1;
              r_state <= S_RSP;
            end else begin
              r_err   <= 1'b0;
              r_cyc   <= 1'b1;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (w_term) begin
            r_cyc   <= 1'b0;
            // ERR beats ACK; a timeout without ACK is an error.
            r_err   <= ERR || !ACK;
            r_state <= S_RSP;
          end
        end
        S_RSP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = w_grant;
  assign rsp_valid_o = (r_state == S_RSP) ? (N_REQ'(1) << r_gidx) : '0;
  assign rsp_err_o   = (r_state == S_RSP) && r_err;
  assign CYC         = r_cyc;
  assign STB         = r_cyc;
  assign WE          = r_cyc;
  assign ADR         = r_cyc ? ADDRESS : '0;
  assign DAT_W       = r_data;
  assign SEL         = r_sel;
  assign dbg_state_o = r_state;

endmodule
